// File: rtl/mem_stage_if.sv
// Execute-side, data-memory and writeback signals of the RV32 memory stage.
// The slave modport is the stage itself; the master modport is its surroundings.
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            E_valid_i;
  logic            E_ready_o;
  logic [XLEN-1:0] E_alu_result_i;
  logic [XLEN-1:0] E_rs2_data_i;
  logic [4:0]      E_mem_op_i;
  logic            E_need_dstE_i;
  logic [4:0]      E_dstE_i;

  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [3:0]      dmem_wstrb_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;

  logic            MD_need_dstE_o;
  logic [4:0]      MD_dstE_o;
  logic [XLEN-1:0] data_o;
  logic            memory_vaild_o;
  logic            misalign_o;

  modport slave (
    input  E_valid_i, E_alu_result_i, E_rs2_data_i, E_mem_op_i, E_need_dstE_i, E_dstE_i,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output E_ready_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output MD_need_dstE_o, MD_dstE_o, data_o, memory_vaild_o, misalign_o
  );

  modport master (
    output E_valid_i, E_alu_result_i, E_rs2_data_i, E_mem_op_i, E_need_dstE_i, E_dstE_i,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  E_ready_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  MD_need_dstE_o, MD_dstE_o, data_o, memory_vaild_o, misalign_o
  );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory stage: byte/half/word loads and stores over a req/gnt/rvalid bus.
// Optional misaligned-access fault reporting is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic        clk_i,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t state, state_nxt;

  logic            accept, is_mem, mem_go, misalign_acc;
  logic            uns_p1, need_p1, we_p1;
  logic [1:0]      size_p1, off_p1;
  logic [4:0]      dst_p1;
  logic [XLEN-1:0] addr_p1, wdata_p1;
  logic [3:0]      strb_p1;
  logic            vld_p2, need_p2;
  logic [4:0]      dst_p2;
  logic [XLEN-1:0] data_p2;
  logic            ret_nxt, ret_need_nxt;
  logic [4:0]      ret_dst_nxt;
  logic [XLEN-1:0] ret_data_nxt;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << {off[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] rs2);
    logic [XLEN-1:0] w;
    case (size)
      2'b00:   w = {4{rs2[7:0]}};
      2'b01:   w = {2{rs2[15:0]}};
      default: w = rs2;
    endcase
    return w;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word, input logic [1:0] size,
                                                  input logic uns, input logic [1:0] off);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{(XLEN-8){b[7] & ~uns}}, b};
      2'b01:   r = {{(XLEN-16){h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept = bus.E_valid_i & (state == IDLE);
  assign is_mem = bus.E_mem_op_i[4];
  assign mem_go = accept & is_mem & ~misalign_acc;

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_p2;

  // Byte accesses can never be misaligned; reserved size is checked like a word.
  assign misalign_acc = is_mem &
                        (((bus.E_mem_op_i[1:0] == 2'b01) & bus.E_alu_result_i[0]) |
                         (bus.E_mem_op_i[1] & (bus.E_alu_result_i[1:0] != 2'b00)));

  always_ff @(posedge clk_i) begin
    if (!rst) mis_p2 <= 1'b0;
    else      mis_p2 <= accept & misalign_acc;
  end

  assign bus.misalign_o = mis_p2;
`else
  assign misalign_acc   = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_go) state_nxt = REQ;
      REQ:     if (bus.dmem_gnt_i) state_nxt = we_p1 ? IDLE : WAIT;
      WAIT:    if (bus.dmem_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Retire selection: non-mem/faulting accept, granted store, or returned load.
  always_comb begin
    bus.E_ready_o  = (state == IDLE);
    bus.dmem_req_o = (state == REQ);
    ret_nxt        = 1'b0;
    ret_need_nxt   = 1'b0;
    ret_dst_nxt    = dst_p2;
    ret_data_nxt   = data_p2;
    case (state)
      IDLE: begin
        if (accept && (!is_mem || misalign_acc)) begin
          ret_nxt      = 1'b1;
          ret_need_nxt = bus.E_need_dstE_i & ~is_mem;
          ret_dst_nxt  = bus.E_dstE_i;
          ret_data_nxt = bus.E_alu_result_i;
        end
      end
      REQ: begin
        if (bus.dmem_gnt_i && we_p1) begin
          ret_nxt     = 1'b1;
          ret_dst_nxt = dst_p1;
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid_i) begin
          ret_nxt      = 1'b1;
          ret_need_nxt = need_p1;
          ret_dst_nxt  = dst_p1;
          ret_data_nxt = load_extract(bus.dmem_rdata_i, size_p1, uns_p1, off_p1);
        end
      end
      default: ;
    endcase
  end

  // Stage p1: bus request fields, held from the first REQ cycle until grant.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      strb_p1  <= '0;
    end else if (mem_go) begin
      we_p1    <= bus.E_mem_op_i[3];
      addr_p1  <= {bus.E_alu_result_i[XLEN-1:2], 2'b00};
      wdata_p1 <= store_wdata(bus.E_mem_op_i[1:0], bus.E_rs2_data_i);
      strb_p1  <= store_strb(bus.E_mem_op_i[1:0], bus.E_alu_result_i[1:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_go) begin
      uns_p1  <= bus.E_mem_op_i[2];
      size_p1 <= bus.E_mem_op_i[1:0];
      off_p1  <= bus.E_alu_result_i[1:0];
      need_p1 <= bus.E_need_dstE_i;
      dst_p1  <= bus.E_dstE_i;
    end
  end

  // Stage p2: writeback triple and single-cycle retire strobe.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      need_p2 <= 1'b0;
      dst_p2  <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= ret_nxt;
      need_p2 <= ret_need_nxt;
      dst_p2  <= ret_dst_nxt;
      data_p2 <= ret_data_nxt;
    end
  end

  assign bus.dmem_we_o      = we_p1;
  assign bus.dmem_addr_o    = addr_p1;
  assign bus.dmem_wdata_o   = wdata_p1;
  assign bus.dmem_wstrb_o   = strb_p1;
  assign bus.memory_vaild_o = vld_p2;
  assign bus.MD_need_dstE_o = need_p2;
  assign bus.MD_dstE_o      = dst_p2;
  assign bus.data_o         = data_p2;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random traffic against a
// transaction-level model of the stage and a byte-lane model of memory.
module tb_mem_stage;

  typedef struct {
    logic        need;
    logic [4:0]  dst;
    logic [31:0] data;
    bit          store;
    bit          mis;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic resp_en = 1'b0;
  logic r_gnt = 1'b0, r_rv = 1'b0, m_gnt = 1'b0, m_rv = 1'b0;
  logic [31:0] r_rdata = 32'h0, m_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];
  req_t req_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] dut_mem [16];

  mem_stage_if #(.XLEN(32)) bus ();

  mem_stage #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.dmem_gnt_i    = r_gnt | m_gnt;
  assign bus.dmem_rvalid_i = r_rv | m_rv;
  assign bus.dmem_rdata_i  = resp_en ? r_rdata : m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Lowest byte the access touches once its offset is rounded down to its size.
  function automatic int base_byte(input logic [1:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr[1:0]);
    return off - (off % nbytes(size));
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] m;
    int b, n;
    b = base_byte(size, addr);
    n = nbytes(size);
    m = 4'b0000;
    for (int i = 0; i < 4; i++) if (i >= b && i < b + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] rs2);
    logic [31:0] w;
    int n;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    logic [31:0] v, mask;
    int n;
    n = nbytes(size);
    if (n == 4) return word;
    v = word >> (8 * base_byte(size, addr));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
    return (int'(addr[1:0]) % nbytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push_exp(input logic need, input logic [4:0] dst, input logic [31:0] data,
                                   input bit store, input bit mis);
    exp_t e;
    e.need = need; e.dst = dst; e.data = data; e.store = store; e.mis = mis;
    exp_q.push_back(e);
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic need, input logic [4:0] dst);
    int n;
    n = 0;
    while (bus.E_ready_o !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
      finish_run();
    end
    bus.E_valid_i      = 1'b1;
    bus.E_mem_op_i     = op;
    bus.E_alu_result_i = alu;
    bus.E_rs2_data_i   = rs2;
    bus.E_need_dstE_i  = need;
    bus.E_dstE_i       = dst;
    @(negedge clk);
    bus.E_valid_i      = 1'b0;
    bus.E_alu_result_i = $urandom;
    bus.E_rs2_data_i   = $urandom;
  endtask

  // Retire scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.memory_vaild_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_retire actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ret_need", bus.MD_need_dstE_o, e.need);
        chk("ret_misalign", bus.misalign_o, e.mis);
        if (!e.store) chk("ret_data", bus.data_o, e.data);
        if (!e.store && !e.mis) chk("ret_dst", bus.MD_dstE_o, e.dst);
      end
    end
  end

  // Random-latency memory for the random phase; stores land via the DUT's own strobes.
  initial begin
    req_t r;
    bit have_r;
    int d;
    logic cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0] cap_strb;
    forever begin
      @(negedge clk);
      if (resp_en && rst === 1'b1 && bus.dmem_req_o === 1'b1) begin
        have_r = (req_q.size() != 0);
        if (have_r) r = req_q.pop_front();
        else begin
          checks++;
          failures++;
          $display("FAIL unexpected_request actual=1 required=0");
        end
        d = $urandom_range(0, 3);
        for (int k = 0; k <= d; k++) begin
          if (k > 0) @(negedge clk);
          if (have_r) begin
            chk("req_held", bus.dmem_req_o, 1'b1);
            chk("req_we", bus.dmem_we_o, r.we);
            chk("req_addr", bus.dmem_addr_o, r.addr);
            if (r.we) begin
              chk("req_wdata", bus.dmem_wdata_o, r.wdata);
              chk("req_wstrb", bus.dmem_wstrb_o, r.strb);
            end
          end
        end
        r_gnt     = 1'b1;
        cap_we    = bus.dmem_we_o;
        cap_addr  = bus.dmem_addr_o;
        cap_wdata = bus.dmem_wdata_o;
        cap_strb  = bus.dmem_wstrb_o;
        @(negedge clk);
        r_gnt = 1'b0;
        if (cap_we) begin
          for (int i = 0; i < 4; i++)
            if (cap_strb[i]) dut_mem[cap_addr[5:2]][8*i +: 8] = cap_wdata[8*i +: 8];
        end else begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          r_rv    = 1'b1;
          r_rdata = dut_mem[cap_addr[5:2]];
          @(negedge clk);
          r_rv    = 1'b0;
          r_rdata = $urandom;
        end
      end
    end
  end

  initial begin
    bus.E_valid_i      = 1'b0;
    bus.E_alu_result_i = 32'h0;
    bus.E_rs2_data_i   = 32'h0;
    bus.E_mem_op_i     = 5'h0;
    bus.E_need_dstE_i  = 1'b0;
    bus.E_dstE_i       = 5'h0;

    // Reset with a stray rvalid pulse.
    rst = 1'b0;
    @(negedge clk);
    m_rv = 1'b1;
    @(negedge clk);
    m_rv = 1'b0;
    chk("rst_ready", bus.E_ready_o, 1'b1);
    chk("rst_req", bus.dmem_req_o, 1'b0);
    chk("rst_we", bus.dmem_we_o, 1'b0);
    chk("rst_addr", bus.dmem_addr_o, 32'h0);
    chk("rst_wdata", bus.dmem_wdata_o, 32'h0);
    chk("rst_wstrb", bus.dmem_wstrb_o, 4'h0);
    chk("rst_need", bus.MD_need_dstE_o, 1'b0);
    chk("rst_dst", bus.MD_dstE_o, 5'h0);
    chk("rst_data", bus.data_o, 32'h0);
    chk("rst_valid", bus.memory_vaild_o, 1'b0);
    chk("rst_misalign", bus.misalign_o, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_retire", bus.memory_vaild_o, 1'b0);

    // Hand-computed lane results pin the model itself.
    chk("model_sb_strb", model_strb(2'b00, 32'h1002), 4'b0100);
    chk("model_sb_wdata", model_wdata(2'b00, 32'hAABBCCDD), 32'hDDDDDDDD);
    chk("model_sh_wdata", model_wdata(2'b01, 32'hAABBCCDD), 32'hCCDDCCDD);
    chk("model_lb", model_load(32'h80F17F00, 2'b00, 1'b0, 32'h2001), 32'h0000007F);
    chk("model_lh", model_load(32'h80F17F00, 2'b01, 1'b0, 32'h2002), 32'hFFFF80F1);
    chk("model_lhu", model_load(32'h80F17F00, 2'b01, 1'b1, 32'h2002), 32'h000080F1);

    // Back-to-back ALU results retire on consecutive cycles.
    push_exp(1'b1, 5'd5, 32'h11, 1'b0, 1'b0);
    issue(5'b00000, 32'h11, 32'h0, 1'b1, 5'd5);
    chk("b2b_v1", bus.memory_vaild_o, 1'b1);
    chk("b2b_d1", bus.data_o, 32'h11);
    push_exp(1'b1, 5'd5, 32'h22, 1'b0, 1'b0);
    issue(5'b00000, 32'h22, 32'h0, 1'b1, 5'd5);
    chk("b2b_v2", bus.memory_vaild_o, 1'b1);
    chk("b2b_d2", bus.data_o, 32'h22);
    push_exp(1'b1, 5'd5, 32'h33, 1'b0, 1'b0);
    issue(5'b00000, 32'h33, 32'h0, 1'b1, 5'd5);
    chk("b2b_v3", bus.memory_vaild_o, 1'b1);
    chk("b2b_d3", bus.data_o, 32'h33);
    chk("b2b_dst", bus.MD_dstE_o, 5'd5);
    @(negedge clk);
    chk("b2b_end", bus.memory_vaild_o, 1'b0);

    // SB held stable until a late grant.
    push_exp(1'b0, 5'd7, 32'h0, 1'b1, 1'b0);
    issue(5'b11000, 32'h1002, 32'hAABBCCDD, 1'b1, 5'd7);
    for (int k = 0; k < 4; k++) begin
      chk("sb_req", bus.dmem_req_o, 1'b1);
      chk("sb_we", bus.dmem_we_o, 1'b1);
      chk("sb_addr", bus.dmem_addr_o, 32'h1000);
      chk("sb_wstrb", bus.dmem_wstrb_o, 4'b0100);
      chk("sb_wdata", bus.dmem_wdata_o, 32'hDDDDDDDD);
      if (k < 3) @(negedge clk);
    end
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    chk("sb_retire", bus.memory_vaild_o, 1'b1);
    chk("sb_need", bus.MD_need_dstE_o, 1'b0);
    chk("sb_req_drop", bus.dmem_req_o, 1'b0);

    // Loads with rvalid two cycles after grant.
    for (int t = 0; t < 3; t++) begin
      logic [4:0] op;
      logic [31:0] a, want;
      op   = (t == 0) ? 5'b10000 : (t == 1) ? 5'b10001 : 5'b10101;
      a    = (t == 0) ? 32'h2001 : 32'h2002;
      want = (t == 0) ? 32'h0000007F : (t == 1) ? 32'hFFFF80F1 : 32'h000080F1;
      push_exp(1'b1, 5'd10, want, 1'b0, 1'b0);
      issue(op, a, 32'h0, 1'b1, 5'd10);
      chk("ld_req", bus.dmem_req_o, 1'b1);
      chk("ld_we", bus.dmem_we_o, 1'b0);
      chk("ld_addr", bus.dmem_addr_o, 32'h2000);
      m_gnt = 1'b1;
      @(negedge clk);
      m_gnt = 1'b0;
      @(negedge clk);
      chk("ld_wait_no_retire", bus.memory_vaild_o, 1'b0);
      m_rv = 1'b1;
      m_rdata = 32'h80F17F00;
      @(negedge clk);
      m_rv = 1'b0;
      m_rdata = 32'h0;
      chk("ld_retire", bus.memory_vaild_o, 1'b1);
      chk("ld_data", bus.data_o, want);
    end

    // Reset while waiting for load data; the late rvalid must be ignored.
    issue(5'b10010, 32'h2000, 32'h0, 1'b1, 5'd9);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_rv = 1'b1;
    m_rdata = 32'h12345678;
    @(negedge clk);
    m_rv = 1'b0;
    @(negedge clk);
    chk("rstwait_ready", bus.E_ready_o, 1'b1);
    chk("rstwait_req", bus.dmem_req_o, 1'b0);
    chk("rstwait_no_retire", bus.memory_vaild_o, 1'b0);
    push_exp(1'b1, 5'd3, 32'h55, 1'b0, 1'b0);
    issue(5'b00000, 32'h55, 32'h0, 1'b1, 5'd3);
    chk("rstwait_add_retire", bus.memory_vaild_o, 1'b1);
    chk("rstwait_add_data", bus.data_o, 32'h55);

`ifdef MEM_MISALIGN_CHECK_EN
    push_exp(1'b0, 5'd4, 32'h3002, 1'b0, 1'b1);
    issue(5'b10010, 32'h3002, 32'h0, 1'b1, 5'd4);
    chk("mis_no_req", bus.dmem_req_o, 1'b0);
    chk("mis_retire", bus.memory_vaild_o, 1'b1);
    chk("mis_flag", bus.misalign_o, 1'b1);
    chk("mis_data", bus.data_o, 32'h3002);
    chk("mis_need", bus.MD_need_dstE_o, 1'b0);
`endif

    // Random traffic in a 16-word window at 0x4000.
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      dut_mem[i]   = model_mem[i];
    end
    @(negedge clk);
    resp_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      logic [4:0] op;
      logic [31:0] alu, rs2, wd;
      logic [3:0] sm;
      logic need, uns, st;
      logic [4:0] dst;
      logic [1:0] sz;
      int kind, idx;
      req_t r;
      kind = $urandom_range(0, 9);
      need = 1'($urandom);
      dst  = 5'($urandom);
      rs2  = $urandom;
      if (kind < 3) begin
        op  = {1'b0, 4'($urandom)};
        alu = $urandom;
        push_exp(need, dst, alu, 1'b0, 1'b0);
      end else begin
        sz  = 2'($urandom);
        uns = 1'($urandom);
        st  = (kind >= 7);
        alu = 32'h4000 + 32'($urandom_range(0, 63));
        op  = {1'b1, st, uns, sz};
        idx = int'(alu[5:2]);
        if (model_mis(sz, alu)) begin
          push_exp(1'b0, dst, alu, 1'b0, 1'b1);
        end else if (st) begin
          sm = model_strb(sz, alu);
          wd = model_wdata(sz, rs2);
          for (int i = 0; i < 4; i++) if (sm[i]) model_mem[idx][8*i +: 8] = wd[8*i +: 8];
          r.we = 1'b1; r.addr = {alu[31:2], 2'b00}; r.wdata = wd; r.strb = sm;
          req_q.push_back(r);
          push_exp(1'b0, dst, 32'h0, 1'b1, 1'b0);
        end else begin
          r.we = 1'b0; r.addr = {alu[31:2], 2'b00}; r.wdata = 32'h0; r.strb = 4'h0;
          req_q.push_back(r);
          push_exp(need, dst, model_load(model_mem[idx], sz, uns, alu), 1'b0, 1'b0);
        end
      end
      issue(op, alu, rs2, need, dst);
    end

    begin
      int n;
      n = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0) && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("drain_retires", exp_q.size(), 0);
    chk("drain_requests", req_q.size(), 0);
    for (int i = 0; i < 16; i++) chk("mem_word", dut_mem[i], model_mem[i]);

    finish_run();
  end

endmodule
